bist_misr_analyzer: RTL

- Response-side stage downstream of the BIST controller; compacts circuit-under-test (CUT) responses into a multiple-input signature register (MISR) while a BIST run is active.
- Capture and run framing come directly from the controller outputs RUNNING, OUT (wired to SHIFT_EN) and BIST_END.
- At end of run, checks the signature and capture count against golden values and holds a PASS/FAIL verdict until the next run starts.

---
 rtl/bist_misr_analyzer_if.sv | 25 ++
 rtl/bist_misr_analyzer.sv | 111 +++++++++++
 2 files changed

// File: rtl/bist_misr_analyzer_if.sv
// Bus between the BIST controller / CUT side and the MISR response analyzer.
// The controller side drives the run framing and response word; the analyzer returns signature and verdict.
interface bist_misr_analyzer_if #(
  parameter int W = 8
);
  logic         RUNNING;
  logic         SHIFT_EN;
  logic         BIST_END;
  logic [W-1:0] DATA_IN;
  logic [W-1:0] SIGNATURE;
  logic [7:0]   CAPTURE_CNT;
  logic         DONE;
  logic         PASS;
  logic         FAIL;

  modport master (
    output RUNNING, SHIFT_EN, BIST_END, DATA_IN,
    input  SIGNATURE, CAPTURE_CNT, DONE, PASS, FAIL
  );

  modport slave (
    input  RUNNING, SHIFT_EN, BIST_END, DATA_IN,
    output SIGNATURE, CAPTURE_CNT, DONE, PASS, FAIL
  );
endinterface

// File: rtl/bist_misr_analyzer.sv
// MISR response compactor with run framing from the BIST controller.
// A golden signature and capture count are checked at end of run, and the verdict is held until the next run starts.
module bist_misr_analyzer #(
  parameter int           W            = 8,
  parameter logic [W-1:0] POLY         = 8'h1D,
  parameter logic [W-1:0] SEED         = 8'h00,
  parameter logic [W-1:0] GOLDEN       = 8'h00,
  parameter int           EXP_CAPTURES = 72
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  bist_misr_analyzer_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COMPACT, EVAL, HOLD} state_t;

  localparam logic [7:0] EXP_CNT = 8'(EXP_CAPTURES);
  localparam logic [7:0] CNT_MAX = 8'hFF;

  function automatic logic [W-1:0] misr_step(input logic [W-1:0] sig, input logic [W-1:0] din);
    misr_step = {sig[W-2:0], 1'b0} ^ (sig[W-1] ? POLY : {W{1'b0}}) ^ din;
  endfunction

  state_t       state_q, state_d;
  logic [W-1:0] sig_q, sig_d;
  logic [7:0]   cnt_q, cnt_d;
  logic         done_q, done_d;
  logic         pass_q, pass_d;
  logic         fail_q, fail_d;
  logic         run_q;
  logic         start_s;
  logic         match_s;

  assign start_s = bus.RUNNING & ~run_q;
  assign match_s = (sig_q == GOLDEN) && (cnt_q == EXP_CNT);

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= IDLE;
      sig_q   <= SEED;
      cnt_q   <= 8'd0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      fail_q  <= 1'b0;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      fail_q  <= fail_d;
      run_q   <= bus.RUNNING;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    pass_d  = pass_q;
    fail_d  = fail_q;
    case (state_q)
      IDLE, HOLD: begin
        if (start_s) begin
          state_d = COMPACT;
          sig_d   = SEED;
          cnt_d   = 8'd0;
          done_d  = 1'b0;
          pass_d  = 1'b0;
          fail_d  = 1'b0;
        end else begin
          state_d = state_q;
        end
      end
      COMPACT: begin
        // End-of-test outranks both abort and a same-cycle shift.
        if (bus.BIST_END) begin
          state_d = EVAL;
        end else if (!bus.RUNNING) begin
          state_d = HOLD;
          done_d  = 1'b1;
          pass_d  = 1'b0;
          fail_d  = 1'b1;
        end else if (bus.SHIFT_EN) begin
          sig_d = misr_step(sig_q, bus.DATA_IN);
          cnt_d = (cnt_q == CNT_MAX) ? CNT_MAX : cnt_q + 8'd1;
        end else begin
          state_d = COMPACT;
        end
      end
      EVAL: begin
        state_d = HOLD;
        done_d  = 1'b1;
        pass_d  = match_s;
        fail_d  = ~match_s;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.SIGNATURE   = sig_q;
  assign bus.CAPTURE_CNT = cnt_q;
  assign bus.DONE        = done_q;
  assign bus.PASS        = pass_q;
  assign bus.FAIL        = fail_q;

endmodule
